// File: rtl/keypad_scanner_3x4_if.sv
// Keypad scanner bus: row sense in, column drive and key event outputs.
// Ports: row_n, col_n, key_code, key_valid, key_down (master = scanner).
interface keypad_scanner_3x4_if;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scanner_3x4.sv
// 3x4 keypad column scanner with frame-based debounce and press events.
// Ports: clk, rst_n (async, active-low), kp (row_n in; col_n/key_* out).
module keypad_scanner_3x4 #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_scanner_3x4_if.master  kp
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_N);

    // Frame results share the key-code space; 14 is never a key.
    localparam logic [3:0] RES_NONE  = 4'hF;
    localparam logic [3:0] RES_MULTI = 4'hE;

    typedef enum logic {
        IDLE,
        DOWN
    } state_t;

    state_t        state;
    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    col_idx;
    logic [2:0]    col_n_q;
    logic [7:0]    acc;
    logic [3:0]    prev_res;
    logic [3:0]    stab;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_down_q;

    logic          tick;
    logic          frame_end;
    logic [11:0]   hits;
    logic [3:0]    n_hits;
    logic [3:0]    hit_code;
    logic [3:0]    frame_res;
    logic [3:0]    stab_next;

    function automatic logic [3:0] key_map(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] k;
        if (r == 2'd3) begin
            unique case (c)
                2'd0:    k = 4'd10;
                2'd1:    k = 4'd0;
                default: k = 4'd11;
            endcase
        end else begin
            k = 4'({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return k;
    endfunction

    assign tick      = (tick_cnt == TICK_LAST);
    assign frame_end = tick && (col_idx == 2'd2);

    // Bit index is col*4+row; column 2 is classified live on its tick.
    assign hits = {~row_s2, acc};

    always_comb begin
        n_hits   = 4'd0;
        hit_code = RES_NONE;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (hits[c*4 + r]) begin
                    n_hits   = n_hits + 4'd1;
                    hit_code = key_map(2'(r), 2'(c));
                end
            end
        end
    end

    always_comb begin
        frame_res = RES_MULTI;
        if (n_hits == 4'd0)
            frame_res = RES_NONE;
        else if (n_hits == 4'd1)
            frame_res = hit_code;
    end

    always_comb begin
        stab_next = 4'd1;
        if (frame_res == prev_res)
            stab_next = (stab >= DEB) ? DEB : stab + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kp.row_n;
            row_s2 <= row_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            col_idx  <= 2'd0;
            col_n_q  <= 3'b110;
            acc      <= 8'h00;
        end else if (tick) begin
            tick_cnt <= '0;
            col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            col_n_q  <= {col_n_q[1:0], col_n_q[2]};
            if (col_idx == 2'd0)
                acc[3:0] <= ~row_s2;
            if (col_idx == 2'd1)
                acc[7:4] <= ~row_s2;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_res    <= RES_NONE;
            stab        <= 4'd0;
            key_code_q  <= 4'hF;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_end) begin
                prev_res <= frame_res;
                stab     <= stab_next;
                unique case (state)
                    IDLE: begin
                        if (frame_res != RES_NONE &&
                            frame_res != RES_MULTI &&
                            stab_next == DEB) begin
                            state       <= DOWN;
                            key_code_q  <= frame_res;
                            key_valid_q <= 1'b1;
                            key_down_q  <= 1'b1;
                        end
                    end
                    DOWN: begin
                        // Other keys or MULTI are ignored until a clean release.
                        if (frame_res == RES_NONE &&
                            stab_next == DEB) begin
                            state      <= IDLE;
                            key_down_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.col_n     = col_n_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner_3x4.sv
// Directed bench for keypad_scanner_3x4 with a keypad switch-matrix model.
// SCAN_DIV=4, DEBOUNCE_N=3: 12-cycle frames.
module tb_keypad_scanner_3x4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] pressed = '0;
    logic [3:0] row_model;
    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;

    keypad_scanner_3x4_if kp();

    keypad_scanner_3x4 #(
        .SCAN_DIV(4),
        .DEBOUNCE_N(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kp(kp)
    );

    always #5 clk = ~clk;

    // Key index is row*3+col; a pressed key pulls its row low when its column is driven.
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3 + c] && !kp.col_n[c])
                    row_model[r] = 1'b0;
    end
    assign kp.row_n = row_model;

    always begin
        @(posedge clk);
        #1;
        if (kp.key_valid === 1'b1)
            valid_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic align_frame;
        logic [2:0] prev;
        bit found;
        found = 0;
        prev = kp.col_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kp.col_n == 3'b110 && prev == 3'b011) begin
                found = 1;
                break;
            end
            prev = kp.col_n;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL align_frame: got no frame start, required one within 40 cycles");
        end
    endtask

    task automatic wait_valid(input int max, output bit got, output int lat);
        int start;
        start = valid_cnt;
        got = 0;
        lat = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (valid_cnt != start) begin
                got = 1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input int max, output bit got);
        got = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (kp.key_down === 1'b0) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [2:0] pat [3];
        logic [2:0] exp_col;
        pat = '{3'b110, 3'b101, 3'b011};
        rst_n = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (kp.col_n !== 3'b110) begin
            failures++;
            $display("FAIL rst_col: got %b required 110", kp.col_n);
        end
        checks++;
        if (kp.key_code !== 4'hF) begin
            failures++;
            $display("FAIL rst_code: got %h required f", kp.key_code);
        end
        checks++;
        if (kp.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid: got %b required 0", kp.key_valid);
        end
        checks++;
        if (kp.key_down !== 1'b0) begin
            failures++;
            $display("FAIL rst_down: got %b required 0", kp.key_down);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            exp_col = pat[(k / 4) % 3];
            checks++;
            if (kp.col_n !== exp_col) begin
                failures++;
                $display("FAIL col_seq[%0d]: got %b required %b", k, kp.col_n, exp_col);
            end
        end
    endtask

    task automatic test_bounce;
        int v0;
        align_frame();
        v0 = valid_cnt;
        pressed[6] = 1'b1;
        repeat (24) @(negedge clk);
        pressed = '0;
        repeat (60) @(negedge clk);
        checks++;
        if (valid_cnt != v0) begin
            failures++;
            $display("FAIL short_valid: got %0d pulses required 0", valid_cnt - v0);
        end
        checks++;
        if (kp.key_code !== 4'hF) begin
            failures++;
            $display("FAIL short_code: got %h required f", kp.key_code);
        end
        align_frame();
        v0 = valid_cnt;
        for (int f = 0; f < 10; f++) begin
            pressed[6] = (f % 2 == 0);
            repeat (12) @(negedge clk);
        end
        pressed = '0;
        repeat (48) @(negedge clk);
        checks++;
        if (valid_cnt != v0) begin
            failures++;
            $display("FAIL toggle_valid: got %0d pulses required 0", valid_cnt - v0);
        end
        checks++;
        if (kp.key_code !== 4'hF) begin
            failures++;
            $display("FAIL toggle_code: got %h required f", kp.key_code);
        end
    endtask

    task automatic test_single_press;
        int v0;
        int lat;
        bit got;
        align_frame();
        v0 = valid_cnt;
        pressed[4] = 1'b1;
        wait_valid(39, got, lat);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL k5_valid: got no pulse required one within 39 cycles");
        end
        checks++;
        if (kp.key_code !== 4'd5) begin
            failures++;
            $display("FAIL k5_code: got %0d required 5", kp.key_code);
        end
        checks++;
        if (kp.key_down !== 1'b1) begin
            failures++;
            $display("FAIL k5_down: got %b required 1", kp.key_down);
        end
        @(negedge clk);
        checks++;
        if (kp.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL k5_pulse_width: got %b required 0", kp.key_valid);
        end
        repeat (120 - lat) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 1) begin
            failures++;
            $display("FAIL k5_held_once: got %0d pulses required 1", valid_cnt - v0);
        end
        align_frame();
        pressed = '0;
        wait_release(39, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL k5_release: got key_down=%b required 0 within 39", kp.key_down);
        end
        checks++;
        if (kp.key_code !== 4'd5) begin
            failures++;
            $display("FAIL k5_code_hold: got %0d required 5", kp.key_code);
        end
    endtask

    task automatic test_special_keys;
        int idx [3];
        logic [3:0] code [3];
        int v0;
        int lat;
        bit got;
        idx = '{9, 10, 11};
        code = '{4'd10, 4'd0, 4'd11};
        for (int i = 0; i < 3; i++) begin
            align_frame();
            v0 = valid_cnt;
            pressed[idx[i]] = 1'b1;
            wait_valid(39, got, lat);
            checks++;
            if (!got || kp.key_code !== code[i]) begin
                failures++;
                $display("FAIL special_code[%0d]: got %0d (pulse=%0d) required %0d", i, kp.key_code, got, code[i]);
            end
            repeat (24) @(negedge clk);
            align_frame();
            pressed = '0;
            wait_release(39, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL special_release[%0d]: got key_down=%b required 0", i, kp.key_down);
            end
            checks++;
            if (valid_cnt - v0 != 1) begin
                failures++;
                $display("FAIL special_pulses[%0d]: got %0d required 1", i, valid_cnt - v0);
            end
        end
    endtask

    task automatic test_multi_keys;
        int v0;
        int lat;
        bit got;
        align_frame();
        v0 = valid_cnt;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        repeat (72) @(negedge clk);
        checks++;
        if (valid_cnt != v0) begin
            failures++;
            $display("FAIL multi_valid: got %0d pulses required 0", valid_cnt - v0);
        end
        checks++;
        if (kp.key_down !== 1'b0) begin
            failures++;
            $display("FAIL multi_down: got %b required 0", kp.key_down);
        end
        pressed = '0;
        repeat (48) @(negedge clk);
        align_frame();
        v0 = valid_cnt;
        pressed[1] = 1'b1;
        wait_valid(39, got, lat);
        checks++;
        if (!got || kp.key_code !== 4'd2) begin
            failures++;
            $display("FAIL k2_code: got %0d (pulse=%0d) required 2", kp.key_code, got);
        end
        pressed[2] = 1'b1;
        repeat (60) @(negedge clk);
        pressed[1] = 1'b0;
        repeat (72) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 1) begin
            failures++;
            $display("FAIL rollover_valid: got %0d pulses required 1", valid_cnt - v0);
        end
        checks++;
        if (kp.key_down !== 1'b1) begin
            failures++;
            $display("FAIL rollover_down: got %b required 1", kp.key_down);
        end
        checks++;
        if (kp.key_code !== 4'd2) begin
            failures++;
            $display("FAIL rollover_code: got %0d required 2", kp.key_code);
        end
        align_frame();
        pressed = '0;
        wait_release(39, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL k3_release: got key_down=%b required 0", kp.key_down);
        end
    endtask

    task automatic test_reset_mid_press;
        int lat;
        bit got;
        align_frame();
        pressed[7] = 1'b1;
        wait_valid(39, got, lat);
        checks++;
        if (!got || kp.key_code !== 4'd8 || kp.key_down !== 1'b1) begin
            failures++;
            $display("FAIL k8_pre: got code=%0d down=%b required 8/1", kp.key_code, kp.key_down);
        end
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (kp.key_code !== 4'hF || kp.key_down !== 1'b0 ||
            kp.key_valid !== 1'b0 || kp.col_n !== 3'b110) begin
            failures++;
            $display("FAIL midrst_outs: got code=%h down=%b valid=%b col=%b required f/0/0/110",
                     kp.key_code, kp.key_down, kp.key_valid, kp.col_n);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(43, got, lat);
        checks++;
        if (!got || kp.key_code !== 4'd8) begin
            failures++;
            $display("FAIL k8_reaccept: got code=%0d (pulse=%0d) required 8", kp.key_code, got);
        end
        checks++;
        if (kp.key_down !== 1'b1) begin
            failures++;
            $display("FAIL k8_down: got %b required 1", kp.key_down);
        end
        pressed = '0;
        repeat (48) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_press();
        test_special_keys();
        test_multi_keys();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_3x4.md
# keypad_scanner_3x4

Scans a 4-row × 3-column telephone-style keypad and debounces it. Produces a 4-bit key code for the seven-segment decoder's `num` input. The code convention is 0–9 for digits, 10 for `*` (shown as dot point), 11 for `#`, and 15 for blank. It sits directly upstream of the seven-segment decoder and also drives any logic that consumes key-press events.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven before its rows are sampled; legal range ≥ 4.
- `DEBOUNCE_N`, default 4: consecutive identical frame results required to accept a press or a release; legal range 1–15.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `row_n`  in  4  keypad rows, active-low, pulled up externally, asynchronous to `clk`.
- `col_n`  out  3  column drive; exactly one bit low at any time.
- `key_code`  out  4  last accepted key, held until the next accepted press; feeds the decoder's `num` input.
- `key_valid`  out  1  one-cycle pulse when a new press is accepted.
- `key_down`  out  1  high while an accepted key is considered held.

## Operation
- **Row synchronizer:** `row_n` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- **Tick counter:** counts 0..SCAN_DIV-1 and wraps. The terminal count is the tick.
- **Sampling on tick:**
  - synchronized rows are captured for the current column;
  - `col_n` then rotates 110 → 101 → 011 → 110.
- **Frame:** one frame is 3 ticks, covering columns 0, 1, 2.
- **Key map** (rows 0–3 top to bottom, columns 0–2 left to right):
  - row0: 1 2 3
  - row1: 4 5 6
  - row2: 7 8 9
  - row3: `*`(10) 0 `#`(11)
- **Frame result** is classified on the column-2 tick:
  - NONE: no row low in any column;
  - KEY(k): exactly one row/column intersection low;
  - MULTI: two or more intersections low.
- **Stability counter:**
  - resets to 1 when the frame result differs from the previous frame result;
  - otherwise increments, saturating at DEBOUNCE_N.
  - The previous-result register updates every frame.
- **FSM states:** IDLE, DOWN.
  - IDLE → DOWN when the result is KEY(k) and the stability counter reaches DEBOUNCE_N. Actions: `key_code`←k, `key_valid` pulses, `key_down`←1.
  - DOWN → IDLE when the result is NONE and the stability counter reaches DEBOUNCE_N. Action: `key_down`←0. `key_code` is unchanged.
  - In DOWN, KEY(j≠k) and MULTI cause no action. A new key is accepted only after a full debounced release.
  - MULTI never causes a transition.
- **Arithmetic:**
  - tick counter width is clog2(SCAN_DIV);
  - stability counter is 4 bits;
  - column index is 2 bits and wraps 2 → 0; value 3 is unreachable.

## Timing
- **Reset values** (applied asynchronously):
  - `col_n`=3'b110, `key_code`=4'hF, `key_valid`=0, `key_down`=0;
  - state IDLE, tick counter 0, column index 0;
  - previous result NONE, stability counter 0;
  - synchronizer flops all 1.
- **Reset deassertion:** the first tick occurs SCAN_DIV cycles after reset deasserts.
- **Column settling:** `col_n` changes in the cycle after a tick. Rows are sampled at the next tick, which leaves SCAN_DIV−1 cycles of settling including the 2-cycle synchronizer latency.
- **Frame period:** 3·SCAN_DIV cycles.
- **Output update:** `key_valid`, `key_code` and `key_down` change on the clock edge that closes a frame, so they are registered. `key_valid` is high for exactly that one cycle.
- **Press latency:** from a clean press to `key_valid`, between (DEBOUNCE_N−1)·3·SCAN_DIV + 3 and (DEBOUNCE_N+1)·3·SCAN_DIV + 3 cycles. Release latency follows the same bounds.
- **Reset mid-operation:**
  - all outputs return to reset values immediately;
  - a pending `key_valid` is lost;
  - a key held through reset is re-accepted after a fresh debounce.
- **Held key:** a press held indefinitely produces exactly one `key_valid`.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_N=3, giving a 12-cycle frame.
- **Reset check:** assert `rst_n`=0, then release with all rows high. Required: `col_n`=110 / `key_code`=F / `key_valid`=0 / `key_down`=0 during reset. After release, `col_n` follows 110, 101, 011, 110, each held 4 cycles.
- **Single press and release:** hold key 5 (`row_n[1]` low while `col_n`=101) for 120 cycles, then release. Required:
  - exactly one `key_valid` pulse, with `key_code`=5 and `key_down`=1, within 39 cycles of the press;
  - after release, `key_down`=0 within 39 cycles;
  - `key_code` stays 5.
- **Special keys:** press `*`, then `0`, then `#` in turn, each with a clean debounced release. Required: `key_code` = 10, 0, 11 in sequence, with one `key_valid` pulse each.
- **Bounce / short glitch:** press key 7 for 2 frames only, or toggle it every frame for 10 frames. Required: no `key_valid`; `key_code` stays F.
- **Multiple keys:**
  - keys 1 and 9 pressed together: no `key_valid`.
  - while 2 is accepted and held, press 3, then release 2 with 3 still held: no new `key_valid`, `key_down` stays 1.
  - release 3: `key_down` goes to 0.
- **Reset mid-press:** assert reset while 8 is held in DOWN state, release reset with 8 still held. Required:
  - outputs at reset values immediately;
  - one new `key_valid` with `key_code`=8 within 39 cycles of reset release plus the first tick.
